// File: rtl/audio_pkg.sv
// audio_pkg: shared types for the I2S frame buffer.
//   rd_state_t              reader FSM state encoding
//   MODE_LEFT/RIGHT/MONO    channel-select codes for the mode input (3 reads as left)
package audio_pkg;

  typedef enum logic [1:0] {
    RD_IDLE    = 2'd0,
    RD_FETCH   = 2'd1,
    RD_PRESENT = 2'd2
  } rd_state_t;

  localparam logic [1:0] MODE_LEFT  = 2'd0;
  localparam logic [1:0] MODE_RIGHT = 2'd1;
  localparam logic [1:0] MODE_MONO  = 2'd2;

endpackage

// File: rtl/i2s_frame_buffer_if.sv
// i2s_frame_buffer_if: frame output stream (valid/ready).
//   out_valid  producer -> consumer  beat valid
//   out_ready  consumer -> producer  beat accepted when high with out_valid
//   out_data   producer -> consumer  sample, OUT_W bits
//   out_index  producer -> consumer  position in frame, IDX_W bits
//   out_last   producer -> consumer  high on the final sample of a frame
interface i2s_frame_buffer_if #(
  parameter int OUT_W = 12,
  parameter int IDX_W = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [IDX_W-1:0] out_index;
  logic             out_last;

  modport master (output out_valid, out_data, out_index, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_index, out_last, output out_ready);
endinterface

// File: rtl/frame_ram.sv
// frame_ram: simple dual-port RAM, one write port and one registered read port.
// No reset and no read enable so it maps onto block RAM.
//   clk    clock
//   we     write enable; waddr/wdata write port
//   raddr  read address; rdata is mem[raddr] one clock later
module frame_ram #(
  parameter  int WIDTH = 12,
  parameter  int DEPTH = 512,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/i2s_frame_buffer.sv
// i2s_frame_buffer: ping-pong frame buffer between the I2S receiver and the DFT.
// Decimates the stereo stream, selects left/right/mono, truncates to OUT_W and
// collects FRAME_LEN samples per bank; full banks are streamed out one sample
// every two clocks.
//   clk, reset_n          system clock, async active-low reset
//   in_valid/left/right   one-cycle stereo frame strobe with both channel words
//   mode                  0 left, 1 right, 2 mono average, 3 left; latched per frame
//   out_s                 frame stream (valid/ready, data, index, last)
//   overrun               sticky: sample dropped with both banks full
//   clear_overrun         synchronous clear of overrun
//   drop_count            only with I2S_FRAME_BUFFER_DROP_CNT_EN: saturating drop counter
//
// Reader FSM:
//   state      | meaning
//   RD_IDLE    | waiting for bank_full[rd_bank]; RAM already addressed at {rd_bank,0}
//   RD_FETCH   | RAM read of {rd_bank,rd_idx} in flight
//   RD_PRESENT | out_valid high, holding until out_ready
module i2s_frame_buffer
  import audio_pkg::*;
#(
  parameter int IN_W      = 32,
  parameter int OUT_W     = 12,
  parameter int FRAME_LEN = 256,
  parameter int DECIM     = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  input  logic [IN_W-1:0] in_left,
  input  logic [IN_W-1:0] in_right,
  input  logic [1:0]      mode,
  i2s_frame_buffer_if.master out_s,
  output logic            overrun,
  input  logic            clear_overrun
`ifdef I2S_FRAME_BUFFER_DROP_CNT_EN
  ,
  output logic [15:0]     drop_count
`endif
);

  localparam int IDX_W  = $clog2(FRAME_LEN);
  localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(FRAME_LEN - 1);
  localparam logic [DCNT_W-1:0] DCNT_TOP = DCNT_W'(DECIM - 1);

  logic [DCNT_W-1:0] dec_cnt;
  logic              wr_bank, rd_bank;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [1:0]        bank_full;
  logic [1:0]        mode_q, eff_mode;
  logic [IN_W:0]     mono_sum;
  logic [OUT_W-1:0]  conv, ram_q;
  logic              accept, wr_ok, drop, wr_last, rd_free;
  rd_state_t         rd_state;
  logic              out_valid_q, out_last_q;
  logic [IDX_W-1:0]  out_index_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      dec_cnt <= '0;
    else if (in_valid) dec_cnt <= (dec_cnt == DCNT_TOP) ? '0 : dec_cnt + DCNT_W'(1);
  end

  assign accept  = in_valid && (dec_cnt == '0);
  assign drop    = accept && bank_full[wr_bank];
  assign wr_ok   = accept && !bank_full[wr_bank];
  assign wr_last = (wr_idx == IDX_LAST);

  // The first sample of a frame uses the live mode; the rest use the copy latched with it.
  assign mono_sum = {in_left[IN_W-1], in_left} + {in_right[IN_W-1], in_right};
  always_comb begin
    eff_mode = (wr_idx == '0) ? mode : mode_q;
    case (eff_mode)
      MODE_RIGHT: conv = in_right[IN_W-1 -: OUT_W];
      MODE_MONO:  conv = mono_sum[IN_W -: OUT_W];
      default:    conv = in_left[IN_W-1 -: OUT_W];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_bank <= 1'b0;
      wr_idx  <= '0;
      mode_q  <= MODE_LEFT;
      overrun <= 1'b0;
    end else begin
      if (wr_ok) begin
        if (wr_idx == '0) mode_q <= mode;
        wr_idx <= wr_idx + IDX_W'(1);
        if (wr_last) wr_bank <= ~wr_bank;
      end
      // A drop in the same cycle as the clear wins.
      if (drop)               overrun <= 1'b1;
      else if (clear_overrun) overrun <= 1'b0;
    end
  end

  // Writer only completes a bank that was empty and reader only frees a full
  // one, so the two updates never touch the same bit.
  assign rd_free = (rd_state == RD_PRESENT) && out_s.out_ready && out_last_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_full <= 2'b00;
    end else begin
      if (rd_free)           bank_full[rd_bank] <= 1'b0;
      if (wr_ok && wr_last)  bank_full[wr_bank] <= 1'b1;
    end
  end

  frame_ram #(.WIDTH(OUT_W), .DEPTH(2 * FRAME_LEN)) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr ({wr_bank, wr_idx}),
    .wdata (conv),
    .raddr ({rd_bank, rd_idx}),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state    <= RD_IDLE;
      rd_bank     <= 1'b0;
      rd_idx      <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (bank_full[rd_bank]) rd_state <= RD_FETCH;
        end
        RD_FETCH: begin
          rd_state    <= RD_PRESENT;
          out_valid_q <= 1'b1;
          out_index_q <= rd_idx;
          out_last_q  <= (rd_idx == IDX_LAST);
        end
        RD_PRESENT: begin
          if (out_s.out_ready) begin
            out_valid_q <= 1'b0;
            rd_idx      <= rd_idx + IDX_W'(1);
            if (out_last_q) begin
              rd_bank  <= ~rd_bank;
              rd_state <= RD_IDLE;
            end else begin
              rd_state <= RD_FETCH;
            end
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // The RAM output register is the data register: the read address cannot move
  // while presenting and the bank being read is full, so it is never rewritten.
  // Gating keeps out_data at zero out of reset and between beats.
  assign out_s.out_valid = out_valid_q;
  assign out_s.out_index = out_index_q;
  assign out_s.out_last  = out_last_q;
  assign out_s.out_data  = out_valid_q ? ram_q : '0;

`ifdef I2S_FRAME_BUFFER_DROP_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         drop_count <= '0;
    else if (clear_overrun)               drop_count <= drop ? 16'd1 : 16'd0;
    else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_i2s_frame_buffer.sv
module tb_i2s_frame_buffer;
  import audio_pkg::*;

  localparam int IDX_W = 3;

  typedef struct packed {
    logic [11:0] d;
    logic [2:0]  i;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0, in_valid4 = 1'b0, clear_overrun = 1'b0;
  logic [31:0] in_left = '0, in_right = '0;
  logic [1:0]  mode = MODE_LEFT;
  logic        overrun, overrun4;
`ifdef I2S_FRAME_BUFFER_DROP_CNT_EN
  logic [15:0] drop_count, drop_count4;
`endif

  always #10 clk = ~clk;

  i2s_frame_buffer_if #(.OUT_W(12), .IDX_W(IDX_W)) sif ();
  i2s_frame_buffer_if #(.OUT_W(12), .IDX_W(IDX_W)) sif4 ();

  i2s_frame_buffer #(.IN_W(32), .OUT_W(12), .FRAME_LEN(8), .DECIM(1)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_left(in_left),
    .in_right(in_right), .mode(mode), .out_s(sif), .overrun(overrun),
    .clear_overrun(clear_overrun)
`ifdef I2S_FRAME_BUFFER_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  i2s_frame_buffer #(.IN_W(32), .OUT_W(12), .FRAME_LEN(8), .DECIM(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid4), .in_left(in_left),
    .in_right(in_right), .mode(mode), .out_s(sif4), .overrun(overrun4),
    .clear_overrun(clear_overrun)
`ifdef I2S_FRAME_BUFFER_DROP_CNT_EN
    , .drop_count(drop_count4)
`endif
  );

  beat_t exp_q[$], exp4_q[$];
  int    n_tests = 0, n_fail = 0;
  bit    stim_done;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push(input int d, input int i, input bit l);
    exp_q.push_back({12'(d), 3'(i), l});
  endtask

  task automatic pulse(input logic [31:0] l, input logic [31:0] r);
    in_left  = l;
    in_right = r;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || exp4_q.size() != 0 || sif.out_valid) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    check({name, "_pending"}, 32'(exp_q.size() + exp4_q.size()), 32'd0);
  endtask

  // Scoreboard monitor for the DECIM=1 instance: pops on every handshake and
  // checks that a stalled beat does not move.
  beat_t held_b, cur_b, exp_b;
  bit    held = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      held = 1'b0;
    end else begin
      cur_b = {sif.out_data, sif.out_index, sif.out_last};
      if (held && sif.out_valid) check("stall_hold", 32'(cur_b), 32'(held_b));
      if (sif.out_valid && sif.out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL beat_unexpected: got %h expected none at %0t", cur_b, $time);
        end else begin
          exp_b = exp_q.pop_front();
          check("beat", 32'(cur_b), 32'(exp_b));
        end
        held = 1'b0;
      end else if (sif.out_valid) begin
        held   = 1'b1;
        held_b = cur_b;
      end else begin
        held = 1'b0;
      end
    end
  end

  beat_t cur4_b, exp4_b;
  always @(negedge clk) begin
    if (reset_n && sif4.out_valid && sif4.out_ready) begin
      cur4_b = {sif4.out_data, sif4.out_index, sif4.out_last};
      if (exp4_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL decim_unexpected: got %h expected none at %0t", cur4_b, $time);
      end else begin
        exp4_b = exp4_q.pop_front();
        check("decim_beat", 32'(cur4_b), 32'(exp4_b));
      end
    end
  end

  initial begin
    int n;
    sif.out_ready  = 1'b1;
    sif4.out_ready = 1'b1;

    // reset state
    @(posedge clk); #1;
    check("rst_valid", 32'(sif.out_valid), 32'd0);
    check("rst_data",  32'(sif.out_data),  32'd0);
    check("rst_index", 32'(sif.out_index), 32'd0);
    check("rst_last",  32'(sif.out_last),  32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    idle(2);
    reset_n = 1'b1;
    idle(2);

    // left frame + latency
    mode = MODE_LEFT;
    for (int k = 0; k < 8; k++) begin
      push(k, k, k == 7);
      pulse(32'(k) << 20, 32'h0);
    end
    n = 0;
    while (!sif.out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'd2);
    drain("left");

    // right frame; mode changed after index 0 must not affect the frame
    mode = MODE_RIGHT;
    for (int k = 0; k < 8; k++) begin
      if (k == 1) mode = MODE_LEFT;
      push(100 + k, k, k == 7);
      pulse(32'hABC0_0000, 32'(100 + k) << 20);
    end
    drain("right_latch");

    // mono
    mode = MODE_MONO;
    for (int k = 0; k < 8; k++) begin
      push(12'h400, k, k == 7);
      pulse(32'h7FF0_0000, 32'h0010_0000);
    end
    for (int k = 0; k < 8; k++) begin
      push(12'h800, k, k == 7);
      pulse(32'h8000_0000, 32'h8000_0000);
    end
    drain("mono");
    mode = MODE_LEFT;

    // decimation by 4 on the second instance
    for (int k = 0; k < 32; k++) begin
      if (k % 4 == 0) exp4_q.push_back({12'(k), 3'(k / 4), k == 28});
      in_left   = 32'(k) << 20;
      in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
    end
    drain("decim");

    // backpressure: two banks fill, 8 samples dropped
    check("overrun_pre", 32'(overrun), 32'd0);
    sif.out_ready = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (k < 16) push(k, k % 8, (k % 8) == 7);
      pulse(32'(k) << 20, 32'h0);
    end
    idle(3);
    check("overrun_set", 32'(overrun), 32'd1);
`ifdef I2S_FRAME_BUFFER_DROP_CNT_EN
    check("drop_count_8", 32'(drop_count), 32'd8);
`endif
    sif.out_ready = 1'b1;
    drain("backpressure");
    check("overrun_sticky", 32'(overrun), 32'd1);
    clear_overrun = 1'b1;
    @(posedge clk); #1;
    clear_overrun = 1'b0;
    check("overrun_clear", 32'(overrun), 32'd0);
`ifdef I2S_FRAME_BUFFER_DROP_CNT_EN
    check("drop_count_clr", 32'(drop_count), 32'd0);
`endif

    // mid-operation reset: one stalled full frame plus a partial one
    sif.out_ready = 1'b0;
    for (int k = 0; k < 13; k++) pulse(32'(200 + k) << 20, 32'h0);
    idle(2);
    check("pre_reset_valid", 32'(sif.out_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_valid", 32'(sif.out_valid), 32'd0);
    check("reset_data",  32'(sif.out_data),  32'd0);
    check("reset_last",  32'(sif.out_last),  32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    sif.out_ready = 1'b1;
    idle(1);
    for (int k = 0; k < 8; k++) begin
      push(50 + k, k, k == 7);
      pulse(32'(50 + k) << 20, 32'h0);
    end
    drain("after_reset");

    // random stalls over three frames
    stim_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 24; k++) begin
          push(300 + k, k % 8, (k % 8) == 7);
          pulse(32'(300 + k) << 20, 32'h0);
          idle(11);
        end
        stim_done = 1'b1;
      end
      begin
        for (int c = 0; c < 6000 && !(stim_done && exp_q.size() == 0); c++) begin
          @(posedge clk); #1;
          sif.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    sif.out_ready = 1'b1;
    drain("random_stall");
    check("overrun_random", 32'(overrun), 32'd0);
    check("overrun_decim", 32'(overrun4), 32'd0);
`ifdef I2S_FRAME_BUFFER_DROP_CNT_EN
    check("drop_count_decim", 32'(drop_count4), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
